// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler framing one requester word per UART frame (ID header byte, then word MSB-byte first).
module uart_tx_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 24
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [7:0]                   tx_data_o,
  output logic                         tx_valid_o,
  input  logic                         tx_ready_i,
  output logic                         busy_o,
  output logic [3:0]                   grant_id_o,
  output logic [15:0]                  frames_o
);
  localparam int NB = DATA_BITS / 8;
  localparam int CW = $clog2(NB) + 1;
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t               state;
  logic [DATA_BITS-1:0] sreg;
  logic [CW-1:0]        byte_cnt;
  logic [3:0]           last_grant;
  logic [3:0]           g;
  logic                 found;
  int                   best;
  int                   d;
  // Pick the valid requester at the smallest rotated distance past last_grant.
  always_comb begin
    best = NUM_REQ;
    d = 0;
    g = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
      if (req_valid_i[i] && d < best) begin
        best = d;
        g = 4'(i);
      end
    end
    found = best < NUM_REQ;
  end
  assign req_ready_o = (state == IDLE && found) ? NUM_REQ'(1) << g : '0;
  assign tx_valid_o  = state != IDLE;
  assign busy_o      = state != IDLE;
  assign tx_data_o   = state == HDR ? {4'hA, grant_id_o} : state == DATA ? sreg[DATA_BITS-1 -: 8] : 8'h00;
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      sreg       <= '0;
      byte_cnt   <= '0;
      last_grant <= 4'(NUM_REQ - 1);
      grant_id_o <= '0;
      frames_o   <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          sreg       <= req_data_i[int'(g)*DATA_BITS +: DATA_BITS];
          last_grant <= g;
          grant_id_o <= g;
          state      <= HDR;
        end
        HDR: if (tx_ready_i) begin
          byte_cnt <= CW'(NB);
          state    <= DATA;
        end
        DATA: if (tx_ready_i) begin
          sreg     <= sreg << 8;
          byte_cnt <= byte_cnt - 1'b1;
          if (byte_cnt == CW'(1)) begin
            frames_o <= frames_o + 16'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed, table-driven bench for uart_tx_sched (4x24-bit instance plus a 1x8-bit instance).
module tb_uart_tx_sched;
  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [3:0]  req_valid_i;
  logic [95:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        busy_o;
  logic [3:0]  grant_id_o;
  logic [15:0] frames_o;
  logic        v2;
  logic [7:0]  d2;
  logic        ready2;
  logic [7:0]  data2;
  logic        valid2;
  logic        r2;
  logic        busy2;
  logic [3:0]  grant2;
  logic [15:0] frames2;
  int checks = 0;
  int failures = 0;
  always #5 clk_i = ~clk_i;
  uart_tx_sched #(.NUM_REQ(4), .DATA_BITS(24)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .busy_o(busy_o), .grant_id_o(grant_id_o), .frames_o(frames_o)
  );
  uart_tx_sched #(.NUM_REQ(1), .DATA_BITS(8)) dut2 (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_valid_i(v2), .req_data_i(d2),
    .req_ready_o(ready2), .tx_data_o(data2), .tx_valid_o(valid2),
    .tx_ready_i(r2), .busy_o(busy2), .grant_id_o(grant2), .frames_o(frames2)
  );
  logic [33:0] obs;
  assign obs = {req_ready_o, tx_valid_o, tx_data_o, busy_o, grant_id_o, frames_o};
  typedef struct {
    logic [3:0]  valid;
    logic        txr;
    logic [33:0] exp;
  } vec_t;
  vec_t tv[6];
  function automatic logic [33:0] pk(logic [3:0] rdy, logic v, logic [7:0] dat, logic b, logic [3:0] gr, logic [15:0] fr);
    return {rdy, v, dat, b, gr, fr};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk_i);
    rstn_i = 1'b0;
    req_valid_i = '0;
    tx_ready_i = 1'b0;
    v2 = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    #1;
    chk("reset_state", 64'(obs), 64'(pk(4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 16'h0)));
    chk("reset_state2", 64'({ready2, valid2, data2, busy2, frames2}), 64'({1'b0, 1'b0, 8'h00, 1'b0, 16'h0}));
  endtask
  logic [7:0] got[8];
  int n;
  logic prev_stall;
  logic [7:0] prev_data;
  logic granted;
  logic [3:0] gexp;
  initial begin
    rstn_i = 1'b0;
    req_valid_i = '0;
    req_data_i = '0;
    tx_ready_i = 1'b0;
    v2 = 1'b0;
    d2 = '0;
    r2 = 1'b1;
    tv[0] = '{4'b0100, 1'b1, pk(4'b0100, 1'b0, 8'h00, 1'b0, 4'h0, 16'h0)};
    tv[1] = '{4'b0000, 1'b1, pk(4'b0000, 1'b1, 8'hA2, 1'b1, 4'h2, 16'h0)};
    tv[2] = '{4'b0000, 1'b1, pk(4'b0000, 1'b1, 8'h12, 1'b1, 4'h2, 16'h0)};
    tv[3] = '{4'b0000, 1'b1, pk(4'b0000, 1'b1, 8'h34, 1'b1, 4'h2, 16'h0)};
    tv[4] = '{4'b0000, 1'b1, pk(4'b0000, 1'b1, 8'h56, 1'b1, 4'h2, 16'h0)};
    tv[5] = '{4'b0000, 1'b1, pk(4'b0000, 1'b0, 8'h00, 1'b0, 4'h2, 16'h1)};
    // single requester, table driven
    do_reset();
    req_data_i[48 +: 24] = 24'h123456;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      req_valid_i = tv[i].valid;
      tx_ready_i = tv[i].txr;
      #1;
      chk($sformatf("single_vec%0d", i), 64'(obs), 64'(tv[i].exp));
    end
    // round robin with all four held valid
    do_reset();
    req_data_i = {24'h030303, 24'h020202, 24'h010101, 24'h000000};
    tx_ready_i = 1'b1;
    for (int f = 0; f < 5; f++) begin
      gexp = 4'(f % 4);
      @(negedge clk_i);
      req_valid_i = 4'hF;
      #1;
      chk($sformatf("rr_grant%0d", f), 64'({req_ready_o, tx_valid_o}), 64'({4'b0001 << gexp, 1'b0}));
      @(negedge clk_i);
      #1;
      chk($sformatf("rr_hdr%0d", f), 64'({tx_valid_o, tx_data_o, grant_id_o}), 64'({1'b1, 4'hA, gexp, gexp}));
      for (int b = 0; b < 3; b++) begin
        @(negedge clk_i);
        #1;
        chk($sformatf("rr_data%0d_%0d", f, b), 64'({tx_valid_o, tx_data_o}), 64'({1'b1, 4'h0, gexp}));
      end
    end
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    chk("rr_frames", 64'({tx_valid_o, frames_o}), 64'({1'b0, 16'd5}));
    // backpressure: 3 cycles low, 1 high
    do_reset();
    req_data_i[0 +: 24] = 24'hA1B2C3;
    n = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    granted = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk_i);
      tx_ready_i = (cyc % 4 == 3);
      req_valid_i = {3'b000, !granted};
      #1;
      if (req_ready_o[0]) granted = 1'b1;
      if (prev_stall) chk("bp_stable", 64'({tx_valid_o, tx_data_o}), 64'({1'b1, prev_data}));
      if (tx_valid_o && tx_ready_i && n < 8) begin
        got[n] = tx_data_o;
        n++;
      end
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_data = tx_data_o;
    end
    chk("bp_count", 64'(n), 64'd4);
    chk("bp_b0", 64'(got[0]), 64'hA0);
    chk("bp_b1", 64'(got[1]), 64'hA1);
    chk("bp_b2", 64'(got[2]), 64'hB2);
    chk("bp_b3", 64'(got[3]), 64'hC3);
    chk("bp_frames", 64'(frames_o), 64'd1);
    // reset in the middle of a frame
    do_reset();
    req_data_i[24 +: 24] = 24'h112233;
    tx_ready_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 4'b0010;
    #1;
    chk("mid_grant", 64'(req_ready_o), 64'b0010);
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    chk("mid_hdr", 64'(tx_data_o), 64'hA1);
    @(negedge clk_i);
    #1;
    chk("mid_d0", 64'(tx_data_o), 64'h11);
    @(negedge clk_i);
    #1;
    chk("mid_d1", 64'(tx_data_o), 64'h22);
    rstn_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("mid_reset", 64'(obs), 64'(pk(4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 16'h0)));
    rstn_i = 1'b1;
    req_valid_i = 4'hF;
    #1;
    chk("mid_next_grant", 64'(req_ready_o), 64'b0001);
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    chk("mid_next_hdr", 64'({tx_data_o, grant_id_o}), 64'({8'hA0, 4'h0}));
    repeat (4) @(negedge clk_i);
    #1;
    chk("mid_frames", 64'({tx_valid_o, frames_o}), 64'({1'b0, 16'd1}));
    // late requests during DATA
    do_reset();
    req_data_i[24 +: 24] = 24'h445566;
    tx_ready_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 4'b0010;
    #1;
    chk("late_grant1", 64'(req_ready_o), 64'b0010);
    @(negedge clk_i);
    #1;
    chk("late_hdr", 64'({req_ready_o, tx_data_o}), 64'({4'b0000, 8'hA1}));
    @(negedge clk_i);
    req_valid_i = 4'b1000;
    #1;
    chk("late_d0", 64'({req_ready_o, tx_data_o}), 64'({4'b0000, 8'h44}));
    @(negedge clk_i);
    #1;
    chk("late_d1", 64'({req_ready_o, tx_data_o}), 64'({4'b0000, 8'h55}));
    @(negedge clk_i);
    #1;
    chk("late_d2", 64'({req_ready_o, tx_data_o}), 64'({4'b0000, 8'h66}));
    @(negedge clk_i);
    #1;
    chk("late_grant3", 64'({req_ready_o, tx_valid_o}), 64'({4'b1000, 1'b0}));
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    chk("late_hdr3", 64'({grant_id_o, tx_data_o}), 64'({4'h3, 8'hA3}));
    repeat (4) @(negedge clk_i);
    #1;
    chk("late_end", 64'(obs), 64'(pk(4'h0, 1'b0, 8'h00, 1'b0, 4'h3, 16'd2)));
    // frames_o wrap on the single-requester 8-bit instance
    @(negedge clk_i);
    force dut2.frames_o = 16'hFFFF;
    @(negedge clk_i);
    release dut2.frames_o;
    v2 = 1'b1;
    d2 = 8'h5A;
    #1;
    chk("wrap_preload", 64'(frames2), 64'hFFFF);
    chk("wrap_grant", 64'({ready2, valid2}), 64'({1'b1, 1'b0}));
    @(negedge clk_i);
    v2 = 1'b0;
    #1;
    chk("wrap_hdr", 64'({valid2, data2, busy2, grant2}), 64'({1'b1, 8'hA0, 1'b1, 4'h0}));
    @(negedge clk_i);
    #1;
    chk("wrap_data", 64'({valid2, data2, frames2}), 64'({1'b1, 8'h5A, 16'hFFFF}));
    @(negedge clk_i);
    #1;
    chk("wrap_zero", 64'({valid2, busy2, frames2}), 64'({1'b0, 1'b0, 16'h0000}));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin transmit scheduler that shares the single byte-wide UART transmitter between up to 16 word-producing requesters. It sits between the signal-processing sources and the UART TX byte interface inside `uart_top`. It accepts one DATA_BITS-wide word from the granted requester and emits a frame of one header byte carrying the requester ID, followed by the word MSB-byte first. It also counts completed frames.

## Interface
- NUM_REQ, 4, number of requesters; legal range 1..16
- DATA_BITS, 24, word width; must be a multiple of 8, at least 8
- clk_i  input  1  system clock
- rstn_i  input  1  synchronous, active-low reset
- req_valid_i  input  NUM_REQ  bit i set: requester i has a word pending
- req_data_i  input  NUM_REQ*DATA_BITS  requester i word at bits [i*DATA_BITS +: DATA_BITS]
- req_ready_o  output  NUM_REQ  one-hot, one-cycle accept pulse for the granted requester
- tx_data_o  output  8  byte to the UART transmitter
- tx_valid_o  output  1  tx_data_o is valid
- tx_ready_i  input  1  transmitter accepts the byte this cycle
- busy_o  output  1  a frame is in progress (state not IDLE)
- grant_id_o  output  4  ID of the last granted requester
- frames_o  output  16  count of completed frames, wraps modulo 2^16

## Operation
- States: IDLE, HDR, DATA.
- IDLE behaviour:
  - If any req_valid_i bit is set, grant the first set bit searching upward from (last_grant+1) mod NUM_REQ.
  - Drive req_ready_o[g]=1 combinationally in the same cycle.
  - Latch req_data_i for g into the shift register, set last_grant=g and grant_id_o=g, then go to HDR.
  - If no request is pending, stay in IDLE with req_ready_o=0.
- HDR: tx_data_o = {4'hA, g[3:0]}, tx_valid_o=1. On tx_valid_o && tx_ready_i, load byte_cnt = DATA_BITS/8 and go to DATA.
- DATA behaviour:
  - tx_data_o = shift register bits [DATA_BITS-1 -: 8], tx_valid_o=1.
  - On each accepted byte, shift left by 8 and decrement byte_cnt.
  - When the last byte is accepted (byte_cnt==1), increment frames_o and go to IDLE.
- Byte handshake:
  - A transfer occurs only when tx_valid_o && tx_ready_i at a rising edge.
  - While waiting for tx_ready_i, tx_valid_o and tx_data_o stay stable.
  - tx_ready_i is ignored while tx_valid_o=0.
- Requester handshake:
  - A word is consumed only in the req_ready_o cycle.
  - A requester may drop valid before being granted; nothing is captured from it.
  - req_valid_i changes during HDR/DATA have no effect until the next IDLE.
- Fairness: a requester that stays valid is granted within NUM_REQ frames.
- NUM_REQ=1: requester 0 is always granted; header is 8'hA0.
- byte_cnt width is clog2(DATA_BITS/8)+1. frames_o wraps from 0xFFFF to 0x0000 with no flag.

## Timing
- Reset values:
  - state=IDLE, req_ready_o=0, tx_valid_o=0, tx_data_o=8'h00, busy_o=0
  - grant_id_o=0, frames_o=0, last_grant=NUM_REQ-1, so the first grant goes to requester 0
- Reset wins over every other event in the same cycle.
- Reset mid-frame: the frame is abandoned, tx_valid_o is 0 the cycle after the reset edge, the partial frame is not counted, and the word is lost.
- Accept to header valid: the req_ready_o pulse is in cycle N; tx_valid_o (header) is 1 in cycle N+1.
- Frame length with tx_ready_i held at 1: 1+DATA_BITS/8 consecutive cycles of tx_valid_o.
- Frame spacing: at least one IDLE cycle (tx_valid_o=0) between frames, so the frame period is at least 2+DATA_BITS/8 cycles.
- frames_o updates on the edge that accepts the last data byte.
- busy_o is 1 from cycle N+1 through that edge.
- No combinational path from tx_ready_i to any output. req_ready_o depends combinationally only on state, req_valid_i and last_grant.

## Test plan
- **Single requester, 24-bit default:**
  - Stimulus: req_valid_i=4'b0100, data 24'h123456, tx_ready_i=1.
  - Response: req_ready_o=4'b0100 for one cycle, then bytes A2,12,34,56 on consecutive cycles; frames_o=1; grant_id_o=2.
- **All four requesters held valid, words 0x000000..0x030303:**
  - Response: grant order 0,1,2,3,0; headers A0,A1,A2,A3; one idle cycle between frames.
- **Backpressure:**
  - Stimulus: tx_ready_i alternates 3 cycles low, 1 cycle high.
  - Response: tx_data_o stays stable while low; each byte is transferred exactly once; byte order unchanged.
- **Reset mid-frame:**
  - Stimulus: assert rstn_i=0 after the header and one data byte are accepted.
  - Response: outputs return to their reset values next cycle; frames_o=0; the next grant goes to requester 0.
- **Late requests:**
  - Stimulus: req_valid_i[3] rises while requester 1's frame is in DATA; requester 1 drops valid before its next grant.
  - Response: requester 3 is granted in the next IDLE cycle; requester 1 is not re-granted.
- **frames_o wrap:**
  - Stimulus: preload via 65535 frames of DATA_BITS=8, or force, then complete one more frame.
  - Response: frames_o goes 0xFFFF to 0x0000.
